// File: rtl/axis_frame_fifo.sv
`default_nettype none
// ============================================================================
// axis_frame_fifo : store-and-forward AXI-stream frame FIFO feeding the MII MAC
// Revision: 1.0 - initial release
// ============================================================================
module axis_frame_fifo #(
    parameter int DEPTH       = 2048,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             s_axis_data,
    input  logic                   s_axis_valid,
    output logic                   s_axis_ready,
    input  logic                   s_axis_last,
    input  logic                   s_axis_err,
    output logic [7:0]             m_axis_data,
    output logic                   m_axis_valid,
    input  logic                   m_axis_ready,
    output logic                   m_axis_last,
    output logic                   m_axis_err,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic                   frame_done,
    output logic                   drop_err,
    output logic                   drop_overflow
);

    localparam int                     c_PTR_W   = ADDR_WIDTH + 1;
    localparam logic [c_PTR_W-1:0]     c_FULL    = c_PTR_W'(DEPTH);
    localparam logic [c_PTR_W-1:0]     c_PTR_ONE = c_PTR_W'(1);
    localparam logic [COUNT_WIDTH-1:0] c_CNT_MAX = {COUNT_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_WRITE = 1'b0,
        ST_DROP  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [c_PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]       commit_ptr_q, commit_ptr_d;
    logic [c_PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic                     err_seen_q, err_seen_d;
    logic                     done_q, done_d;
    logic                     derr_q, derr_d;
    logic                     dovf_q, dovf_d;
    logic                     m_valid_q, m_valid_d;
    logic [7:0]               m_data_q;
    logic                     m_last_q;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic [8:0]               mem_q [DEPTH];

    logic [c_PTR_W-1:0]       w_used;
    logic                     w_full;
    logic                     w_ovf;
    logic                     w_s_hs;
    logic                     w_wr_en;
    logic                     w_load;
    logic                     w_m_done;

    assign w_used  = wr_ptr_q - rd_ptr_q;
    assign w_full  = (w_used == c_FULL);
    // Buffer is full and nothing committed lies ahead: the open frame can never fit.
    assign w_ovf   = w_full && (rd_ptr_q == commit_ptr_q);

    // The overflow cycle keeps ready high and discards its beat, so the
    // upstream never sees a stall for a frame that is going to be dropped.
    assign s_axis_ready = (state_q == ST_DROP) ? 1'b1 : (!w_full || w_ovf);
    assign w_s_hs       = s_axis_valid && s_axis_ready;
    assign w_wr_en      = (state_q == ST_WRITE) && w_s_hs && !w_ovf;

    assign w_load   = (rd_ptr_q != commit_ptr_q) && (!m_valid_q || m_axis_ready);
    assign w_m_done = m_valid_q && m_axis_ready && m_last_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        err_seen_d   = err_seen_q;
        done_d       = 1'b0;
        derr_d       = 1'b0;
        dovf_d       = 1'b0;
        case (state_q)
            ST_WRITE: begin
                if (w_ovf) begin
                    wr_ptr_d   = commit_ptr_q;
                    err_seen_d = 1'b0;
                    if (w_s_hs && s_axis_last) begin
                        dovf_d = 1'b1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else if (w_s_hs) begin
                    wr_ptr_d = wr_ptr_q + c_PTR_ONE;
                    if (s_axis_last) begin
                        if (err_seen_q || s_axis_err) begin
                            wr_ptr_d   = commit_ptr_q;
                            derr_d     = 1'b1;
                            err_seen_d = 1'b0;
                        end else begin
                            commit_ptr_d = wr_ptr_q + c_PTR_ONE;
                            done_d       = 1'b1;
                        end
                    end else if (s_axis_err) begin
                        err_seen_d = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (w_s_hs && s_axis_last) begin
                    dovf_d  = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            default: state_d = ST_WRITE;
        endcase
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        m_valid_d = m_valid_q;
        if (w_load) begin
            rd_ptr_d  = rd_ptr_q + c_PTR_ONE;
            m_valid_d = 1'b1;
        end else if (m_axis_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // A commit and a final-beat handshake in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        if (done_d && !w_m_done) begin
            if (count_q != c_CNT_MAX) count_d = count_q + 1'b1;
        end else if (w_m_done && !done_d) begin
            if (count_q != '0) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_WRITE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            err_seen_q   <= 1'b0;
            done_q       <= 1'b0;
            derr_q       <= 1'b0;
            dovf_q       <= 1'b0;
            m_valid_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            err_seen_q   <= err_seen_d;
            done_q       <= done_d;
            derr_q       <= derr_d;
            dovf_q       <= dovf_d;
            m_valid_q    <= m_valid_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_last, s_axis_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last_q <= 1'b0;
            m_data_q <= 8'h00;
        end else if (w_load) begin
            {m_last_q, m_data_q} <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    assign m_axis_data   = m_data_q;
    assign m_axis_valid  = m_valid_q;
    assign m_axis_last   = m_last_q;
    assign m_axis_err    = 1'b0;
    assign frame_count   = count_q;
    assign frame_done    = done_q;
    assign drop_err      = derr_q;
    assign drop_overflow = dovf_q;

endmodule
`default_nettype wire
